// File: rtl/data_path_muxs_pkg.sv
// Shared types for the operand-forwarding scoreboard: the forwarding select
// type, the register-file select constant and the in-flight slot record.
package data_path_muxs_pkg;

  // Default register-index width of the datapath.
  localparam int REG_W = 5;

  // Slot rd storage is sized for the widest supported register index so the
  // slot record stays a fixed package type; narrower indices are zero-extended.
  localparam int REG_W_MAX = 8;

  // Select width large enough for the deepest supported scoreboard (6 slots
  // plus the register-file code needs 3 bits).
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] fwd_sel_t;

  // Select code meaning "take the operand from the register file".
  localparam fwd_sel_t FWD_REGFILE = '0;

  // One in-flight result: slot 0 is the youngest (EX), higher slots are older.
  typedef struct packed {
    logic                 valid;
    logic                 wen;
    logic                 load;
    logic [REG_W_MAX-1:0] rd;
  } slot_t;

  // Select code that forwards from slot k.
  function automatic fwd_sel_t slot_sel(input int k);
    return fwd_sel_t'(k + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority lookup of one source register against the scoreboard slots.
// Optional feature macro: FWD_EX_BYPASS_EN (when defined, a non-load result
// sitting in slot 0 may be forwarded; otherwise any slot-0 match stalls).
module fwd_match
  import data_path_muxs_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SRC_W = 5
) (
  input  slot_t [DEPTH-1:0] slots,
  input  logic [SRC_W-1:0]  src,
  input  logic              issue_valid,
  output fwd_sel_t          sel,
  output logic              hazard
);

`ifdef FWD_EX_BYPASS_EN
  localparam bit EX_BYPASS = 1'b1;
`else
  localparam bit EX_BYPASS = 1'b0;
`endif

  logic [REG_W_MAX-1:0] src_ext;
  logic                 found;
  logic                 win_ex;
  logic                 win_load;
  logic                 blocked;
  fwd_sel_t             win_sel;

  assign src_ext = REG_W_MAX'(src);

  // Scan oldest to youngest so the youngest valid writer of src wins; then
  // decide whether that winner can be forwarded or must stall the issue.
  always_comb begin
    found    = 1'b0;
    win_ex   = 1'b0;
    win_load = 1'b0;
    win_sel  = FWD_REGFILE;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slots[k].valid && slots[k].wen && (slots[k].rd == src_ext)) begin
        found    = 1'b1;
        win_ex   = (k == 0);
        win_load = slots[k].load;
        win_sel  = slot_sel(k);
      end
    end
    if (src == '0) begin
      found = 1'b0;
    end
    blocked = found && win_ex && (win_load || !EX_BYPASS);
    sel     = (found && !blocked) ? win_sel : FWD_REGFILE;
    hazard  = issue_valid && blocked;
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard: tracks in-flight results, drives the rs/rt
// operand mux selects, refuses issue on unresolvable hazards and counts the
// stalled cycles (saturating).
// Optional feature macro: FWD_EX_BYPASS_EN (enables forwarding of non-load
// results straight out of the EX slot).
module fwd_scoreboard
  import data_path_muxs_pkg::slot_t;
  import data_path_muxs_pkg::fwd_sel_t;
  import data_path_muxs_pkg::REG_W_MAX;
#(
  parameter int DEPTH = 3,
  parameter int REG_W = 5
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         issue_valid,
  input  logic                         issue_wen,
  input  logic                         issue_load,
  input  logic [REG_W-1:0]             issue_rd,
  input  logic [REG_W-1:0]             src_rs,
  input  logic [REG_W-1:0]             src_rt,
  input  logic                         freeze,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   rs_sel,
  output logic [$clog2(DEPTH+1)-1:0]   rt_sel,
  output logic                         hazard_stall,
  output logic [15:0]                  stall_count
);

  localparam int SW = $clog2(DEPTH + 1);

  slot_t [DEPTH-1:0] slots_q;
  slot_t [DEPTH-1:0] slots_d;
  logic [15:0]       stall_cnt_q;
  logic [15:0]       stall_cnt_d;
  fwd_sel_t          rs_full;
  fwd_sel_t          rt_full;
  logic              rs_haz;
  logic              rt_haz;
  logic              unused_sel_bits;

  fwd_match #(
    .DEPTH (DEPTH),
    .SRC_W (REG_W)
  ) u_match_rs (
    .slots       (slots_q),
    .src         (src_rs),
    .issue_valid (issue_valid),
    .sel         (rs_full),
    .hazard      (rs_haz)
  );

  fwd_match #(
    .DEPTH (DEPTH),
    .SRC_W (REG_W)
  ) u_match_rt (
    .slots       (slots_q),
    .src         (src_rt),
    .issue_valid (issue_valid),
    .sel         (rt_full),
    .hazard      (rt_haz)
  );

  // The package select type is sized for the deepest scoreboard; the ports
  // only carry as many bits as this DEPTH needs.
  assign rs_sel          = SW'(rs_full);
  assign rt_sel          = SW'(rt_full);
  assign unused_sel_bits = ^{rs_full, rt_full};

  assign hazard_stall = rs_haz | rt_haz;
  assign stall_count  = stall_cnt_q;

  // Next slot contents and stall count: freeze holds everything, otherwise
  // the pipeline shifts and slot 0 takes either a bubble (flush or hazard)
  // or the issuing instruction; only a real, unflushed stall is counted.
  always_comb begin
    slots_d     = slots_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      for (int k = 1; k < DEPTH; k++) begin
        slots_d[k] = slots_q[k-1];
      end
      if (flush || hazard_stall) begin
        slots_d[0] = '0;
      end else begin
        slots_d[0] = '{valid: issue_valid,
                       wen:   issue_wen,
                       load:  issue_load,
                       rd:    REG_W_MAX'(issue_rd)};
      end
      if (!flush && hazard_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  // Slot and counter registers; reset empties the scoreboard at once, which
  // also discards any bubble that a pending stall would have inserted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      slots_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard (DEPTH=3). Expectations
// adapt to whether FWD_EX_BYPASS_EN is defined for the build.
module tb_fwd_scoreboard;

  localparam int DEPTH = 3;
  localparam int REG_W = 5;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             issue_valid;
  logic             issue_wen;
  logic             issue_load;
  logic [REG_W-1:0] issue_rd;
  logic [REG_W-1:0] src_rs;
  logic [REG_W-1:0] src_rt;
  logic             freeze;
  logic             flush;
  logic [1:0]       rs_sel;
  logic [1:0]       rt_sel;
  logic             hazard_stall;
  logic [15:0]      stall_count;

  typedef struct {
    int          stepId;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic        haz;
    logic [15:0] cnt;
  } expect_t;

  expect_t     expQ[$];
  int          checkCount = 0;
  int          errorCount = 0;
  int          stepId = 0;
  logic [15:0] expCnt = 16'd0;

  fwd_scoreboard #(
    .DEPTH (DEPTH),
    .REG_W (REG_W)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .issue_valid  (issue_valid),
    .issue_wen    (issue_wen),
    .issue_load   (issue_load),
    .issue_rd     (issue_rd),
    .src_rs       (src_rs),
    .src_rt       (src_rt),
    .freeze       (freeze),
    .flush        (flush),
    .rs_sel       (rs_sel),
    .rt_sel       (rt_sel),
    .hazard_stall (hazard_stall),
    .stall_count  (stall_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 CLK = ~CLK;

  task automatic pushExpect(input logic [1:0] eRs, input logic [1:0] eRt,
                            input logic eHaz);
    expect_t e;
    e.stepId = stepId;
    e.rs     = eRs;
    e.rt     = eRt;
    e.haz    = eHaz;
    e.cnt    = expCnt;
    expQ.push_back(e);
    stepId++;
  endtask

  task automatic checkOutput();
    expect_t e;
    if (expQ.size() == 0) begin
      checkCount++;
      errorCount++;
      $error("[TB] FAIL scoreboard_empty: got 0 entries, expected at least 1");
      return;
    end
    e = expQ.pop_front();
    checkCount++;
    assert (rs_sel === e.rs) else begin
      errorCount++;
      $error("[TB] FAIL step%0d rs_sel: got %0d expected %0d", e.stepId, rs_sel, e.rs);
    end
    checkCount++;
    assert (rt_sel === e.rt) else begin
      errorCount++;
      $error("[TB] FAIL step%0d rt_sel: got %0d expected %0d", e.stepId, rt_sel, e.rt);
    end
    checkCount++;
    assert (hazard_stall === e.haz) else begin
      errorCount++;
      $error("[TB] FAIL step%0d hazard_stall: got %0b expected %0b", e.stepId, hazard_stall, e.haz);
    end
    checkCount++;
    assert (stall_count === e.cnt) else begin
      errorCount++;
      $error("[TB] FAIL step%0d stall_count: got %h expected %h", e.stepId, stall_count, e.cnt);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, record what the outputs
  // must show, check them, then advance the expected stall count.
  task automatic applyStimulus(input logic v, input logic wen, input logic ld,
                               input logic [4:0] rd, input logic [4:0] rs,
                               input logic [4:0] rt, input logic frz,
                               input logic fl, input logic [1:0] eRs,
                               input logic [1:0] eRt, input logic eHaz);
    @(negedge CLK);
    issue_valid = v;
    issue_wen   = wen;
    issue_load  = ld;
    issue_rd    = rd;
    src_rs      = rs;
    src_rt      = rt;
    freeze      = frz;
    flush       = fl;
    pushExpect(eRs, eRt, eHaz);
    #1;
    checkOutput();
    if (!frz && !fl && eHaz && (expCnt != 16'hFFFF)) begin
      expCnt = expCnt + 16'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    end
  endtask

  initial begin
    nRST        = 1'b0;
    issue_valid = 1'b0;
    issue_wen   = 1'b0;
    issue_load  = 1'b0;
    issue_rd    = '0;
    src_rs      = '0;
    src_rt      = '0;
    freeze      = 1'b0;
    flush       = 1'b0;

    // Reset state.
    #3;
    pushExpect(2'd0, 2'd0, 1'b0);
    checkOutput();
    @(negedge CLK);
    nRST = 1'b1;

    // ALU result forwarded to the next instruction.
    applyStimulus(1, 1, 0, 5'd8, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
`ifdef FWD_EX_BYPASS_EN
    applyStimulus(1, 1, 0, 5'd10, 5'd8, 5'd0, 0, 0, 2'd1, 2'd0, 0);
`else
    applyStimulus(1, 1, 0, 5'd10, 5'd8, 5'd0, 0, 0, 2'd0, 2'd0, 1);
    applyStimulus(1, 1, 0, 5'd10, 5'd8, 5'd0, 0, 0, 2'd2, 2'd0, 0);
`endif
    idle(3);

    // Load-use hazard: one stall, then forward from slot 1.
    applyStimulus(1, 1, 1, 5'd9, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 2'd0, 2'd0, 1);
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 2'd0, 2'd2, 0);
    idle(3);

    // Youngest writer wins; r0 never forwards; stale rd in invalid slot ignored.
    applyStimulus(1, 1, 0, 5'd4, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, 1, 0, 5'd5, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, 1, 0, 5'd4, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
`ifdef FWD_EX_BYPASS_EN
    applyStimulus(1, 0, 0, 5'd0, 5'd4, 5'd5, 0, 0, 2'd1, 2'd2, 0);
`else
    applyStimulus(1, 0, 0, 5'd0, 5'd4, 5'd5, 0, 0, 2'd0, 2'd2, 1);
    applyStimulus(1, 0, 0, 5'd0, 5'd4, 5'd5, 0, 0, 2'd2, 2'd3, 0);
`endif
    applyStimulus(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(0, 1, 0, 5'd12, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, 0, 0, 5'd0, 5'd12, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    idle(3);

    // Freeze held across a load-use hazard.
    applyStimulus(1, 1, 1, 5'd9, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 1, 0, 2'd0, 2'd0, 1);
    end
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 2'd0, 2'd0, 1);
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 2'd0, 2'd2, 0);
    idle(3);

    // Flush squashes the issuing writer; flush with hazard is not counted.
    applyStimulus(1, 1, 0, 5'd7, 5'd0, 5'd0, 0, 1, 2'd0, 2'd0, 0);
    applyStimulus(1, 0, 0, 5'd0, 5'd7, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, 1, 1, 5'd9, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 1, 2'd0, 2'd0, 1);
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 2'd0, 2'd2, 0);
    idle(3);

    // Saturation: preload the counter near its limit, then two hazards.
    @(negedge CLK);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    expCnt = 16'hFFFE;
    applyStimulus(1, 1, 1, 5'd9, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 2'd0, 2'd0, 1);
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 2'd0, 2'd2, 0);
    applyStimulus(1, 1, 1, 5'd9, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 2'd0, 2'd0, 1);
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 2'd0, 2'd2, 0);
    idle(3);

    // Reset asserted while a hazard is pending.
    applyStimulus(1, 1, 1, 5'd9, 5'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0);
    @(negedge CLK);
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_load  = 1'b0;
    issue_rd    = 5'd11;
    src_rs      = 5'd0;
    src_rt      = 5'd9;
    pushExpect(2'd0, 2'd0, 1'b1);
    #1;
    checkOutput();
    #2;
    nRST   = 1'b0;
    expCnt = 16'd0;
    #1;
    pushExpect(2'd0, 2'd0, 1'b0);
    checkOutput();
    @(negedge CLK);
    nRST = 1'b1;
    applyStimulus(1, 1, 0, 5'd11, 5'd0, 5'd9, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1, 0, 0, 5'd0, 5'd11, 5'd0, 0, 0,
`ifdef FWD_EX_BYPASS_EN
                  2'd1, 2'd0, 0);
`else
                  2'd0, 2'd0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 3, number of in-flight result slots tracked (2..6).
- REG_W, 5, register-index width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- CLK  in  1  single clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- issue_valid  in  1  instruction presented for issue this cycle.
- issue_wen  in  1  issuing instruction writes a register.
- issue_load  in  1  issuing instruction is a load.
- issue_rd  in  REG_W  destination register of issuing instruction.
- src_rs, src_rt  in  REG_W  source registers of issuing instruction.
- freeze  in  1  external pipeline freeze (e.g. memory wait).
- flush  in  1  squash the issuing instruction (branch mispredict).
- rs_sel, rt_sel  out  $clog2(DEPTH+1)  operand mux select, type fwd_sel_t.
- hazard_stall  out  1  issue refused this cycle.
- stall_count  out  16  saturating count of hazard_stall cycles.

Function
REQ-003 Scoreboard SHALL hold DEPTH slots {valid, wen, load, rd}; slot 0 is youngest (EX), slot DEPTH-1 oldest.
REQ-004 Select encoding SHALL be: 0 = FWD_REGFILE, k+1 = forward from slot k.
REQ-005 Per source (rs, rt independently): youngest valid slot with wen=1, rd==src, src!=0 wins; no match or src==0 -> FWD_REGFILE.
REQ-006 Selects and hazard_stall SHALL be combinational from current slots and inputs (zero latency).
REQ-007 hazard_stall SHALL assert when issue_valid=1 and a winning match is slot 0 with load=1; in that case the affected sel SHALL read FWD_REGFILE.
REQ-008 Advance rule each rising CLK, priority freeze > flush > hazard_stall > normal:
- freeze=1: all slots hold; stall_count holds.
- flush=1: slots shift (k -> k+1, DEPTH-1 retires); slot 0 loads invalid.
- hazard_stall=1: slots shift; slot 0 loads invalid bubble; stall_count increments.
- otherwise: slots shift; slot 0 loads {issue_valid, issue_wen, issue_load, issue_rd}.
REQ-009 Match against a slot with valid=0 SHALL never occur, regardless of stale rd.
REQ-010 stall_count SHALL saturate at 16'hFFFF and not wrap.
REQ-011 freeze and hazard_stall simultaneously: hazard_stall output still asserts, no state change, no count.
REQ-012 flush and hazard_stall simultaneously: flush behaviour, no count.

Reset
REQ-013 nRST low SHALL immediately clear all slot valid bits and stall_count to 0; outputs then read rs_sel=rt_sel=0, hazard_stall=0.
REQ-014 Reset asserted mid-stall SHALL discard the pending bubble; first post-reset issue proceeds with no hazard.

Configuration
REQ-015 Macro FWD_EX_BYPASS_EN defined: non-load match in slot 0 forwards (sel=1).
REQ-016 Macro FWD_EX_BYPASS_EN undefined: any match in slot 0 asserts hazard_stall (no EX bypass); slots 1+ unchanged.

Structure
REQ-017 typedef fwd_sel_t, constants FWD_REGFILE and REG_W, and the slot struct SHALL live in data_path_muxs_pkg.
REQ-018 Priority lookup SHALL be a sub-module fwd_match, instantiated twice (rs, rt).

Verification
REQ-019 Bench SHALL cover (DEPTH=3, FWD_EX_BYPASS_EN defined unless noted):
- Issue add rd=8, next cycle issue src_rs=8 -> rs_sel=1, hazard_stall=0.
- Issue lw rd=9, next cycle src_rt=9 -> hazard_stall=1 one cycle, stall_count=1, then rt_sel=2.
- Slot0 rd=4 and slot2 rd=4 both valid, src_rs=4 -> rs_sel=1; src_rs=0 with rd=0 writer -> rs_sel=0.
- freeze=1 for 5 cycles during lw hazard -> slots unchanged, stall_count unchanged, hazard_stall=1 throughout.
- flush=1 with issue rd=7 -> next cycle src_rs=7 gives rs_sel=0; stall_count preloaded 16'hFFFE, two hazards -> 16'hFFFF.
- Macro undefined: add rd=8 then src_rs=8 -> hazard_stall=1, then rs_sel=2.
